// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and FSM state encoding for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register still owed a MUL/DIV result,
// plus the three-address hazard lookup for decode. x0 is never busy.
module rf_scoreboard
  import rf_arb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic                  dec_valid_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  stall_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-cycle set/clear of one index keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_rd_i] = 1'b0;
    if (set_en_i) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign stall_o = ~rst_i & dec_valid_i & (busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rd_i]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline WB and the MUL/DIV unit.
// Define RF_ARB_STARVE_GUARD_EN to add the starvation counter, FORCE state and op_wb_stall.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  ip_clk,
  input  logic                  ip_rst,
  input  logic                  ip_wb_wr_en,
  input  logic [REG_ADDR_W-1:0] ip_wb_rd_addr,
  input  logic [XLEN-1:0]       ip_wb_wr_data,
  input  logic                  ip_md_issue,
  input  logic [REG_ADDR_W-1:0] ip_md_issue_rd,
  input  logic                  ip_md_valid,
  input  logic [REG_ADDR_W-1:0] ip_md_rd_addr,
  input  logic [XLEN-1:0]       ip_md_data,
  output logic                  op_md_ready,
  input  logic                  ip_dec_valid,
  input  logic [REG_ADDR_W-1:0] ip_dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ip_dec_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ip_dec_rd_addr,
  output logic                  op_dec_stall,
  output logic                  op_wb_stall,
  output logic                  op_rf_wr_en,
  output logic [REG_ADDR_W-1:0] op_rf_rd_addr,
  output logic [XLEN-1:0]       op_rf_wr_data
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic                  buf_valid_q, buf_valid_d;
  logic [REG_ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [XLEN-1:0]       buf_data_q, buf_data_d;
  arb_state_e            state_q, state_d;

  logic pipe_busy;
  logic md_grant;
  logic md_hs;
  logic md_load;

  assign pipe_busy = ip_wb_wr_en & (ip_wb_rd_addr != '0);

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] StarveLim = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign md_grant    = ~ip_rst & buf_valid_q & (~pipe_busy | (state_q == FORCE));
  assign op_wb_stall = ~ip_rst & (state_q == FORCE);

  // Counts cycles a buffered result has been blocked by the pipe; saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (md_grant || state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign md_grant    = ~ip_rst & buf_valid_q & ~pipe_busy;
  assign op_wb_stall = 1'b0;
`endif

  assign op_md_ready = ip_rst | ~buf_valid_q | md_grant;
  assign md_hs       = ip_md_valid & op_md_ready;
  // rd=0 results complete the handshake but never occupy the buffer.
  assign md_load     = md_hs & (ip_md_rd_addr != '0);

  // Skid buffer next-state and arbitration FSM.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    state_d     = state_q;

    if (md_grant) buf_valid_d = 1'b0;
    if (md_load) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = ip_md_rd_addr;
      buf_data_d  = ip_md_data;
    end

    case (state_q)
      IDLE: begin
        if (md_load) state_d = WAIT;
      end
      WAIT: begin
        if (md_grant) begin
          state_d = md_load ? WAIT : IDLE;
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        else if (cnt_d >= StarveLim) begin
          state_d = FORCE;
        end
`endif
      end
      default: begin
        state_d = md_load ? WAIT : IDLE;
      end
    endcase
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      state_q     <= IDLE;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      state_q     <= state_d;
    end
  end

  // Write-port mux: a granted MUL/DIV result overrides the pipeline.
  always_comb begin
    op_rf_wr_en   = 1'b0;
    op_rf_rd_addr = ip_wb_rd_addr;
    op_rf_wr_data = ip_wb_wr_data;
    if (md_grant) begin
      op_rf_wr_en   = 1'b1;
      op_rf_rd_addr = buf_rd_q;
      op_rf_wr_data = buf_data_q;
    end else if (!ip_rst) begin
      op_rf_wr_en   = ip_wb_wr_en;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk_i       (ip_clk),
    .rst_i       (ip_rst),
    .set_en_i    (ip_md_issue),
    .set_rd_i    (ip_md_issue_rd),
    .clr_en_i    (md_grant),
    .clr_rd_i    (buf_rd_q),
    .dec_valid_i (ip_dec_valid),
    .rs1_i       (ip_dec_rs1_addr),
    .rs2_i       (ip_dec_rs2_addr),
    .rd_i        (ip_dec_rd_addr),
    .stall_o     (op_dec_stall)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; RF writes are checked by a cycle-tagged scoreboard.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_stall;
  logic        wb_stall;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          at;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .ip_clk          (clk),
    .ip_rst          (rst),
    .ip_wb_wr_en     (wb_wr_en),
    .ip_wb_rd_addr   (wb_rd),
    .ip_wb_wr_data   (wb_data),
    .ip_md_issue     (md_issue),
    .ip_md_issue_rd  (md_issue_rd),
    .ip_md_valid     (md_valid),
    .ip_md_rd_addr   (md_rd),
    .ip_md_data      (md_data),
    .op_md_ready     (md_ready),
    .ip_dec_valid    (dec_valid),
    .ip_dec_rs1_addr (dec_rs1),
    .ip_dec_rs2_addr (dec_rs2),
    .ip_dec_rd_addr  (dec_rd),
    .op_dec_stall    (dec_stall),
    .op_wb_stall     (wb_stall),
    .op_rf_wr_en     (rf_wr_en),
    .op_rf_rd_addr   (rf_rd),
    .op_rf_wr_data   (rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any RF write must match the scoreboard entry due this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (!(rf_wr_en === 1'b1 && mon_e.at == cyc && rf_rd === mon_e.rd && rf_data === mon_e.data)) begin
        errors++;
        $display("FAIL rf_write cyc=%0d: got en=%0b rd=%0d data=%h, required en=1 rd=%0d data=%h at cyc=%0d",
                 cyc, rf_wr_en, rf_rd, rf_data, mon_e.rd, mon_e.data, mon_e.at);
      end
    end else if (rf_wr_en !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL rf_unexpected cyc=%0d: got write rd=%0d data=%h, required no write", cyc, rf_rd, rf_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  task automatic expect_wr(input int at, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.at = at; e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
    md_issue = 1'b0; md_issue_rd = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    next();
    next();

    // Reset gating: a pipe write during reset must not reach the RF.
    wb_wr_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
    mid();
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd1);
    next();

    // Post-reset values.
    rst = 1'b0;
    idle_inputs();
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd5; dec_rd = 5'd5;
    mid();
    chk("reset_md_ready", 32'(md_ready), 32'd1);
    chk("reset_dec_stall", 32'(dec_stall), 32'd0);
    chk("reset_wb_stall", 32'(wb_stall), 32'd0);
    next();

    // Issue rd=5, then result 0xAA with the pipe idle.
    idle_inputs();
    md_issue = 1'b1; md_issue_rd = 5'd5;
    next();
    idle_inputs();
    dec_valid = 1'b1; dec_rs1 = 5'd5;
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h0000_00AA;
    mid();
    chk("rd5_stall_pending", 32'(dec_stall), 32'd1);
    chk("rd5_ready", 32'(md_ready), 32'd1);
    next();
    md_valid = 1'b0;
    expect_wr(cyc, 5'd5, 32'h0000_00AA);
    mid();
    chk("rd5_wr_en_n1", 32'(rf_wr_en), 32'd1);
    chk("rd5_stall_write_cycle", 32'(dec_stall), 32'd1);
    next();
    mid();
    chk("rd5_busy_cleared", 32'(dec_stall), 32'd0);
    next();

    // x0 is never busy; rd=7 stalls via rs2; same-cycle set+clear keeps it busy.
    idle_inputs();
    md_issue = 1'b1; md_issue_rd = 5'd0;
    next();
    md_issue_rd = 5'd7;
    dec_valid = 1'b1;
    mid();
    chk("x0_never_busy", 32'(dec_stall), 32'd0);
    next();
    md_issue = 1'b0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd7; dec_rd = 5'd1;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h1234_5678;
    mid();
    chk("rs2_7_stall", 32'(dec_stall), 32'd1);
    next();
    md_valid = 1'b0;
    md_issue = 1'b1; md_issue_rd = 5'd7;
    expect_wr(cyc, 5'd7, 32'h1234_5678);
    mid();
    chk("rd7_stall_write_cycle", 32'(dec_stall), 32'd1);
    next();
    md_issue = 1'b0;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h0BAD_F00D;
    mid();
    chk("rd7_set_wins_clear", 32'(dec_stall), 32'd1);
    next();
    md_valid = 1'b0;
    expect_wr(cyc, 5'd7, 32'h0BAD_F00D);
    mid();
    chk("rd7_stall_second_write", 32'(dec_stall), 32'd1);
    next();
    mid();
    chk("rd7_released", 32'(dec_stall), 32'd0);
    next();

    // Back-to-back results: the grant frees the buffer for a same-cycle handshake.
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd11; md_data = 32'h0000_0011;
    next();
    md_rd = 5'd12; md_data = 32'h0000_0012;
    expect_wr(cyc, 5'd11, 32'h0000_0011);
    mid();
    chk("b2b_ready_on_grant", 32'(md_ready), 32'd1);
    next();
    md_valid = 1'b0;
    expect_wr(cyc, 5'd12, 32'h0000_0012);
    next();

    // Starvation: pipe writes every cycle while a result waits in the buffer.
    idle_inputs();
`ifdef RF_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 9; k++) begin
      int p;
      p = (k <= 5) ? k : k - 1;
      wb_wr_en = 1'b1; wb_rd = 5'(16 + p); wb_data = 32'hC000_0000 + 32'(p);
      md_valid = (k == 0); md_rd = 5'd10; md_data = 32'hDEAD_BEEF;
      if (k == 5) expect_wr(cyc, 5'd10, 32'hDEAD_BEEF);
      else        expect_wr(cyc, 5'(16 + p), 32'hC000_0000 + 32'(p));
      mid();
      chk("starve_wb_stall", 32'(wb_stall), 32'(k == 5));
      chk("starve_md_ready", 32'(md_ready), 32'(k == 0 || k >= 5));
      next();
    end
    idle_inputs();
`else
    for (int k = 0; k < 8; k++) begin
      wb_wr_en = 1'b1; wb_rd = 5'(16 + k); wb_data = 32'hC000_0000 + 32'(k);
      md_valid = (k == 0); md_rd = 5'd10; md_data = 32'hDEAD_BEEF;
      expect_wr(cyc, 5'(16 + k), 32'hC000_0000 + 32'(k));
      mid();
      chk("noguard_wb_stall", 32'(wb_stall), 32'd0);
      chk("noguard_md_ready", 32'(md_ready), 32'(k == 0));
      next();
    end
    idle_inputs();
    expect_wr(cyc, 5'd10, 32'hDEAD_BEEF);
    mid();
    chk("noguard_first_idle_ready", 32'(md_ready), 32'd1);
`endif
    next();

    // rd=0 result: accepted and dropped.
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0000_0055;
    mid();
    chk("rd0_ready", 32'(md_ready), 32'd1);
    next();
    md_valid = 1'b0;
    mid();
    chk("rd0_no_write", 32'(rf_wr_en), 32'd0);
    chk("rd0_buffer_empty", 32'(md_ready), 32'd1);
    next();

    // Reset while the buffer holds rd=9 and busy[9] is set.
    idle_inputs();
    md_issue = 1'b1; md_issue_rd = 5'd9;
    next();
    md_issue = 1'b0;
    wb_wr_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h2222_0000;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h0000_0099;
    expect_wr(cyc, 5'd2, 32'h2222_0000);
    next();
    md_valid = 1'b0;
    wb_data = 32'h2222_0001;
    rst = 1'b1;
    mid();
    chk("midrst_wr_gated", 32'(rf_wr_en), 32'd0);
    next();
    rst = 1'b0;
    idle_inputs();
    dec_valid = 1'b1; dec_rs1 = 5'd9;
    mid();
    chk("midrst_busy9_clear", 32'(dec_stall), 32'd0);
    chk("midrst_buffer_empty", 32'(md_ready), 32'd1);
    chk("midrst_no_x9_write", 32'(rf_wr_en), 32'd0);
    next();

    // Post-reset result flows normally, showing the FSM restarted from IDLE.
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h0000_0303;
    next();
    md_valid = 1'b0;
    expect_wr(cyc, 5'd3, 32'h0000_0303);
    next();

    idle_inputs();
    next();
    next();
    mid();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
